// File: rtl/mm_slot_allocator.sv
// Slot allocator for the matching-memory units: tracks per-slot valid bits,
// grants free slots (fixed priority or round-robin across units) and releases them on match results.
module mm_slot_allocator #(
    parameter int NUM_UNITS = 2,
    parameter int SLOTS     = 16,
    parameter int RR_MODE   = 0,
    parameter int CNT_W     = $clog2(SLOTS + 1),
    localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int SLOT_W   = $clog2(SLOTS),
    localparam int TOT      = NUM_UNITS * SLOTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic [NUM_UNITS-1:0]       unit_en,
    input  logic                       alloc_req,
    input  logic                       free_vld,
    input  logic [TOT-1:0]             free_mask,
    output logic                       alloc_gnt,
    output logic [TOT-1:0]             w_en,
    output logic [UNIT_W-1:0]          gnt_unit,
    output logic [SLOT_W-1:0]          gnt_slot,
    output logic [TOT-1:0]             valid,
    output logic [NUM_UNITS*CNT_W-1:0] occ,
    output logic [NUM_UNITS-1:0]       unit_full,
    output logic [NUM_UNITS-1:0]       unit_last_free,
    output logic                       all_full,
    output logic                       err_free_inval
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [TOT-1:0]             valid_q, valid_d;
    logic [NUM_UNITS*CNT_W-1:0] occ_q, occ_d;
    logic [NUM_UNITS-1:0]       full_q, full_d;
    logic                       err_q, err_d;
    logic [UNIT_W-1:0]          ptr_q, ptr_d;

    logic                       run;
    logic [NUM_UNITS-1:0]       has_free;
    logic [NUM_UNITS-1:0]       inval_hit;
    logic [NUM_UNITS*SLOT_W-1:0] low_free;

    logic                       sel_found;
    logic [UNIT_W-1:0]          sel_unit;
    logic [SLOT_W-1:0]          sel_slot;
    logic                       gnt;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Unit search: fixed order from unit 0, or rotating from the unit after the last grant.
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_unit  = '0;
        sel_slot  = '0;
        cand      = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (RR_MODE != 0) begin
                cand = int'(ptr_q) + 1 + i;
                if (cand >= NUM_UNITS) begin
                    cand = cand - NUM_UNITS;
                end
            end else begin
                cand = i;
            end
            if (!sel_found && (|(has_free & (NUM_UNITS'(1) << cand)))) begin
                sel_found = 1'b1;
                sel_unit  = UNIT_W'(cand);
                sel_slot  = SLOT_W'(low_free >> (cand * SLOT_W));
            end
        end
    end

    assign gnt      = run & alloc_req & ~hold & ~free_vld & sel_found;
    assign all_full = run & ~(|has_free);
    assign w_en     = gnt ? (TOT'(1) << (int'(sel_unit) * SLOTS + int'(sel_slot))) : '0;
    assign ptr_d    = gnt ? sel_unit : ptr_q;
    assign err_d    = err_q | (run & free_vld & ~hold & (|inval_hit));

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
        logic [SLOTS-1:0]  v_cur;
        logic [SLOTS-1:0]  f_cur;
        logic [SLOTS-1:0]  w_cur;
        logic [SLOTS-1:0]  v_nxt;
        logic [SLOT_W-1:0] first_free;
        logic [CNT_W-1:0]  cnt_nxt;

        assign v_cur = valid_q[gi*SLOTS +: SLOTS];
        assign f_cur = free_mask[gi*SLOTS +: SLOTS];
        assign w_cur = w_en[gi*SLOTS +: SLOTS];

        assign has_free[gi]  = unit_en[gi] & ~(&v_cur);
        assign inval_hit[gi] = unit_en[gi] & (|(f_cur & ~v_cur));

        always_comb begin
            first_free = '0;
            for (int s = SLOTS - 1; s >= 0; s--) begin
                if (!v_cur[s]) begin
                    first_free = SLOT_W'(s);
                end
            end
        end
        assign low_free[gi*SLOT_W +: SLOT_W] = first_free;

        // A disabled unit is flushed even under hold; w_cur is only non-zero on a real grant.
        always_comb begin
            v_nxt = v_cur;
            if (!unit_en[gi]) begin
                v_nxt = '0;
            end else if (run && !hold) begin
                if (free_vld) begin
                    v_nxt = v_cur & ~f_cur;
                end else begin
                    v_nxt = v_cur | w_cur;
                end
            end
        end

        assign cnt_nxt                        = CNT_W'($countones(v_nxt));
        assign valid_d[gi*SLOTS +: SLOTS]     = v_nxt;
        assign occ_d[gi*CNT_W +: CNT_W]       = cnt_nxt;
        assign full_d[gi]                     = unit_en[gi] & (cnt_nxt == CNT_W'(SLOTS));
        assign unit_last_free[gi]             = run & free_vld & ~hold &
                                                (occ_q[gi*CNT_W +: CNT_W] == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            valid_q <= '0;
            occ_q   <= '0;
            full_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign alloc_gnt      = gnt;
    assign gnt_unit       = gnt ? sel_unit : '0;
    assign gnt_slot       = gnt ? sel_slot : '0;
    assign valid          = valid_q;
    assign occ            = occ_q;
    assign unit_full      = full_q;
    assign err_free_inval = err_q;

endmodule

// File: tb/tb_mm_slot_allocator.sv
// Bench for mm_slot_allocator: a fixed-priority and a round-robin instance share stimulus
// and are compared against a slot-array reference model, a vector table and directed sequences.
module tb_mm_slot_allocator;

    localparam int NU  = 2;
    localparam int SL  = 16;
    localparam int CW  = 5;
    localparam int TOT = NU * SL;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [NU-1:0]   unit_en;
    logic            alloc_req;
    logic            free_vld;
    logic [TOT-1:0]  free_mask;

    logic            gnt_a, gnt_b;
    logic [TOT-1:0]  wen_a, wen_b, val_a, val_b;
    logic [0:0]      gu_a, gu_b;
    logic [3:0]      gs_a, gs_b;
    logic [NU*CW-1:0] occ_a, occ_b;
    logic [NU-1:0]   full_a, full_b, ulf_a, ulf_b;
    logic            af_a, af_b, err_a, err_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state: [instance][unit][slot]; instance 0 fixed priority, 1 round-robin.
    bit mv[2][NU][SL];
    bit mfull[2][NU];
    bit merr[2];
    int mptr[2];
    bit minit;

    typedef struct {
        logic        hold;
        logic [1:0]  en;
        logic        req;
        logic        fv;
        logic [31:0] mask;
        logic        g0;
        int          u0;
        int          s0;
        logic        g1;
        int          u1;
        int          s1;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    mm_slot_allocator #(.NUM_UNITS(NU), .SLOTS(SL), .RR_MODE(0)) u_fixed (
        .clk(clk), .rst(rst), .hold(hold), .unit_en(unit_en), .alloc_req(alloc_req),
        .free_vld(free_vld), .free_mask(free_mask), .alloc_gnt(gnt_a), .w_en(wen_a),
        .gnt_unit(gu_a), .gnt_slot(gs_a), .valid(val_a), .occ(occ_a), .unit_full(full_a),
        .unit_last_free(ulf_a), .all_full(af_a), .err_free_inval(err_a)
    );

    mm_slot_allocator #(.NUM_UNITS(NU), .SLOTS(SL), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .hold(hold), .unit_en(unit_en), .alloc_req(alloc_req),
        .free_vld(free_vld), .free_mask(free_mask), .alloc_gnt(gnt_b), .w_en(wen_b),
        .gnt_unit(gu_b), .gnt_slot(gs_b), .valid(val_b), .occ(occ_b), .unit_full(full_b),
        .unit_last_free(ulf_b), .all_full(af_b), .err_free_inval(err_b)
    );

    function automatic vec_t mk(logic h, logic [1:0] e, logic r, logic f, logic [31:0] m,
                                logic g0, int u0, int s0, logic g1, int u1, int s1);
        vec_t v;
        v.hold = h; v.en = e; v.req = r; v.fv = f; v.mask = m;
        v.g0 = g0; v.u0 = u0; v.s0 = s0; v.g1 = g1; v.u1 = u1; v.s1 = s1;
        return v;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int ucount(int k, int u);
        int n = 0;
        for (int s = 0; s < SL; s++) n += int'(mv[k][u][s]);
        return n;
    endfunction

    function automatic logic [TOT-1:0] mvec(int k);
        logic [TOT-1:0] v = '0;
        for (int u = 0; u < NU; u++)
            for (int s = 0; s < SL; s++) v[u*SL+s] = mv[k][u][s];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int u = 0; u < NU; u++) begin
                for (int s = 0; s < SL; s++) mv[k][u][s] = 1'b0;
                mfull[k][u] = 1'b0;
            end
            merr[k] = 1'b0;
            mptr[k] = 0;
        end
        minit = 1'b1;
    endtask

    // Expected combinational outputs of instance k for the current state and inputs.
    task automatic model_comb(input int k, output bit g, output int gu, output int gs,
                              output logic [TOT-1:0] wen, output logic [NU-1:0] ulf, output bit af);
        bit found = 1'b0;
        int u;
        g = 1'b0; gu = 0; gs = 0; wen = '0; ulf = '0; af = 1'b0;
        if (!minit) begin
            af = 1'b1;
            for (int i = 0; i < NU; i++)
                if (unit_en[i] && ucount(k, i) < SL) af = 1'b0;
            for (int i = 0; i < NU; i++) begin
                u = (k == 0) ? i : (mptr[k] + 1 + i) % NU;
                if (!found && unit_en[u] && ucount(k, u) < SL) begin
                    found = 1'b1;
                    gu = u;
                end
            end
            if (found) begin
                gs = -1;
                for (int s = 0; s < SL; s++)
                    if (gs < 0 && !mv[k][gu][s]) gs = s;
            end
            g = alloc_req && !hold && !free_vld && found;
            if (g) wen[gu*SL+gs] = 1'b1;
            else begin gu = 0; gs = 0; end
            for (int i = 0; i < NU; i++)
                ulf[i] = free_vld && !hold && (ucount(k, i) == 1);
        end
    endtask

    task automatic check_model();
        bit g; int gu; int gs; logic [TOT-1:0] wen; logic [NU-1:0] ulf; bit af;
        logic [TOT-1:0] ev; logic [NU*CW-1:0] eo; logic [NU-1:0] ef;
        logic a_g, a_af, a_err; logic [0:0] a_gu; logic [3:0] a_gs;
        logic [TOT-1:0] a_wen, a_val; logic [NU*CW-1:0] a_occ; logic [NU-1:0] a_full, a_ulf;
        for (int k = 0; k < 2; k++) begin
            model_comb(k, g, gu, gs, wen, ulf, af);
            ev = mvec(k); eo = '0; ef = '0;
            for (int u = 0; u < NU; u++) begin
                eo[u*CW +: CW] = CW'(ucount(k, u));
                ef[u] = mfull[k][u];
            end
            if (k == 0) begin
                a_g = gnt_a; a_gu = gu_a; a_gs = gs_a; a_wen = wen_a; a_val = val_a;
                a_occ = occ_a; a_full = full_a; a_ulf = ulf_a; a_af = af_a; a_err = err_a;
            end else begin
                a_g = gnt_b; a_gu = gu_b; a_gs = gs_b; a_wen = wen_b; a_val = val_b;
                a_occ = occ_b; a_full = full_b; a_ulf = ulf_b; a_af = af_b; a_err = err_b;
            end
            chk("m_alloc_gnt", k, 64'(a_g), 64'(g));
            chk("m_gnt_unit", k, 64'(a_gu), 64'(gu));
            chk("m_gnt_slot", k, 64'(a_gs), 64'(gs));
            chk("m_w_en", k, 64'(a_wen), 64'(wen));
            chk("m_valid", k, 64'(a_val), 64'(ev));
            chk("m_occ", k, 64'(a_occ), 64'(eo));
            chk("m_unit_full", k, 64'(a_full), 64'(ef));
            chk("m_last_free", k, 64'(a_ulf), 64'(ulf));
            chk("m_all_full", k, 64'(a_af), 64'(af));
            chk("m_err", k, 64'(a_err), 64'(merr[k]));
        end
    endtask

    task automatic model_edge();
        bit g; int gu; int gs; logic [TOT-1:0] wen; logic [NU-1:0] ulf; bit af;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            model_comb(k, g, gu, gs, wen, ulf, af);
            for (int u = 0; u < NU; u++) begin
                if (!unit_en[u]) begin
                    for (int s = 0; s < SL; s++) mv[k][u][s] = 1'b0;
                end else if (!minit && !hold) begin
                    if (free_vld) begin
                        for (int s = 0; s < SL; s++) begin
                            if (free_mask[u*SL+s]) begin
                                if (!mv[k][u][s]) merr[k] = 1'b1;
                                mv[k][u][s] = 1'b0;
                            end
                        end
                    end else if (g && gu == u) begin
                        mv[k][u][gs] = 1'b1;
                    end
                end
                mfull[k][u] = unit_en[u] && (ucount(k, u) == SL);
            end
            if (g) mptr[k] = gu;
        end
        minit = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        $display("txn cyc=%0d rst=%0b en=%b hold=%0b req=%0b fv=%0b mask=%h gnt=%0b/%0b unit=%0d/%0d slot=%0d/%0d",
                 cyc, rst, unit_en, hold, alloc_req, free_vld, free_mask, gnt_a, gnt_b, gu_a, gu_b, gs_a, gs_b);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic set_in(logic h, logic [1:0] e, logic r, logic f, logic [31:0] m);
        hold = h; unit_en = e; alloc_req = r; free_vld = f; free_mask = m;
    endtask

    // Reset is raised between edges so the registered outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", 0, 64'(val_a), 64'(0));
        chk("rst_valid", 1, 64'(val_b), 64'(0));
        chk("rst_occ", 0, 64'(occ_a), 64'(0));
        chk("rst_occ", 1, 64'(occ_b), 64'(0));
        chk("rst_full", 0, 64'(full_a), 64'(0));
        chk("rst_err", 0, 64'(err_a), 64'(0));
        chk("rst_err", 1, 64'(err_b), 64'(0));
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(0, 2'b11, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 0, 1, 1, 0);
        tbl[2] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 1, 1, 0, 0);
        tbl[3] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 2, 1, 1, 1);
        tbl[4] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 3, 1, 0, 1);
        tbl[5] = mk(1, 2'b11, 1, 1, 32'h2,        0, 0, 0, 0, 0, 0);
        tbl[6] = mk(0, 2'b11, 1, 1, 32'h2,        0, 0, 0, 0, 0, 0);
        tbl[7] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 1, 1, 1, 2);
        tbl[8] = mk(0, 2'b10, 1, 0, 32'h0,        1, 1, 0, 1, 1, 3);
        tbl[9] = mk(0, 2'b11, 1, 0, 32'h0,        1, 0, 0, 1, 0, 0);

        rst = 1'b1;
        set_in(0, 2'b11, 0, 0, 32'h0);
        model_reset();
        @(posedge clk);
        #1;

        // Fill: INIT cycle gives nothing, then unit0 slots 0..15 and unit1 slots 0..15.
        do_reset();
        set_in(0, 2'b11, 1, 0, 32'h0);
        settle();
        chk("init_gnt", 0, 64'(gnt_a), 64'(0));
        chk("init_gnt", 1, 64'(gnt_b), 64'(0));
        advance();
        for (int i = 0; i < 32; i++) begin
            settle();
            chk("fill_gnt", 0, 64'(gnt_a), 64'(1));
            chk("fill_unit", 0, 64'(gu_a), 64'(i / 16));
            chk("fill_slot", 0, 64'(gs_a), 64'(i % 16));
            advance();
        end
        settle();
        chk("full_all_full", 0, 64'(af_a), 64'(1));
        chk("full_all_full", 1, 64'(af_b), 64'(1));
        chk("full_gnt", 0, 64'(gnt_a), 64'(0));
        chk("full_occ", 0, 64'(occ_a), 64'(10'h210));
        chk("full_unit_full", 0, 64'(full_a), 64'(2'b11));
        advance();

        // Vector table: both priority modes from an empty start.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].hold, tbl[i].en, tbl[i].req, tbl[i].fv, tbl[i].mask);
            settle();
            chk("tbl_gnt", 0, 64'(gnt_a), 64'(tbl[i].g0));
            chk("tbl_gnt", 1, 64'(gnt_b), 64'(tbl[i].g1));
            if (tbl[i].g0) begin
                chk("tbl_unit", 0, 64'(gu_a), 64'(tbl[i].u0));
                chk("tbl_slot", 0, 64'(gs_a), 64'(tbl[i].s0));
            end
            if (tbl[i].g1) begin
                chk("tbl_unit", 1, 64'(gu_b), 64'(tbl[i].u1));
                chk("tbl_slot", 1, 64'(gs_b), 64'(tbl[i].s1));
            end
            advance();
        end

        // Leave unit0 with slots 3 and 7, free them one at a time.
        do_reset();
        set_in(0, 2'b11, 1, 0, 32'h0);
        repeat (9) cycle();
        set_in(0, 2'b11, 0, 1, 32'h77);
        cycle();
        set_in(0, 2'b11, 1, 1, 32'h08);
        settle();
        chk("free_blocks_gnt", 0, 64'(gnt_a), 64'(0));
        chk("free2_last_free", 0, 64'(ulf_a), 64'(0));
        advance();
        set_in(0, 2'b11, 0, 1, 32'h80);
        settle();
        chk("free_occ", 0, 64'(occ_a[4:0]), 64'(1));
        chk("free_valid", 0, 64'(val_a[15:0]), 64'(16'h0080));
        chk("last_free", 0, 64'(ulf_a[0]), 64'(1));
        advance();
        set_in(0, 2'b11, 0, 0, 32'h0);
        settle();
        chk("empty_occ", 0, 64'(occ_a[4:0]), 64'(0));
        chk("no_err_yet", 0, 64'(err_a), 64'(0));
        advance();

        // Freeing an already-empty slot raises the sticky error only.
        set_in(0, 2'b11, 0, 1, 32'h20);
        cycle();
        set_in(0, 2'b11, 0, 0, 32'h0);
        settle();
        chk("inval_err", 0, 64'(err_a), 64'(1));
        chk("inval_valid", 0, 64'(val_a), 64'(0));
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_sticky", 0, 64'(err_a), 64'(1));
            advance();
        end

        // Unit1 at 9 entries dropped under hold; allocation must then skip it.
        do_reset();
        set_in(0, 2'b11, 1, 0, 32'h0);
        repeat (26) cycle();
        set_in(1, 2'b11, 1, 1, 32'h0001_0000);
        settle();
        chk("hold_gnt", 0, 64'(gnt_a), 64'(0));
        chk("hold_last_free", 0, 64'(ulf_a), 64'(0));
        advance();
        set_in(1, 2'b01, 0, 0, 32'h0);
        settle();
        chk("hold_occ", 0, 64'(occ_a), 64'(10'h130));
        advance();
        set_in(0, 2'b01, 0, 1, 32'h4);
        settle();
        chk("flush_occ1", 0, 64'(occ_a[9:5]), 64'(0));
        chk("flush_valid1", 0, 64'(val_a[31:16]), 64'(0));
        advance();
        set_in(0, 2'b01, 1, 0, 32'h0);
        settle();
        chk("skip_gnt", 0, 64'(gnt_a), 64'(1));
        chk("skip_unit", 0, 64'(gu_a), 64'(0));
        chk("skip_slot", 0, 64'(gs_a), 64'(2));
        advance();
        settle();
        chk("skip_none", 0, 64'(gnt_a), 64'(0));
        chk("skip_all_full", 0, 64'(af_a), 64'(1));
        advance();

        // Random traffic against the reference model, with one mid-run reset.
        do_reset();
        set_in(0, 2'b11, 0, 0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            hold      = ($urandom_range(0, 7) == 0);
            alloc_req = 1'($urandom_range(0, 1));
            free_vld  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) free_mask = mvec($urandom_range(0, 1)) & $urandom;
            else free_mask = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 15) == 0) unit_en = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) unit_en = 2'b11;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_slot_allocator.md
Name: mm_slot_allocator

Overview:
Parametrised slot manager for the matching-memory units (MMUs) of the firing-control stage. It tracks per-slot valid bits across NUM_UNITS units of SLOTS entries each. It grants free slots to incoming packets and releases slots on match results. Over the fixed two-unit/16-slot manager it adds: a parametrised unit count and depth, round-robin allocation mode, registered occupancy counters, full/empty flags, and a sticky error for invalid frees.

Parameters:
NUM_UNITS, 2, number of matching-memory units (1..8)
SLOTS, 16, slots per unit (2..64)
RR_MODE, 0, 0 = fixed priority (lowest unit, then lowest slot); 1 = round-robin across units, lowest slot within a unit
CNT_W, $clog2(SLOTS+1), occupancy counter width (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
hold  input  1  uni-operation hold; blocks both alloc and free when 1
unit_en  input  NUM_UNITS  per-unit enable (power-gate status)
alloc_req  input  1  request one slot this cycle
free_vld  input  1  match result valid; release slots in free_mask
free_mask  input  NUM_UNITS*SLOTS  slots to release, bit u*SLOTS+s
alloc_gnt  output  1  slot granted this cycle (combinational)
w_en  output  NUM_UNITS*SLOTS  one-hot write enable of the granted slot, else 0
gnt_unit  output  max(1,$clog2(NUM_UNITS))  unit index of grant
gnt_slot  output  $clog2(SLOTS)  slot index of grant
valid  output  NUM_UNITS*SLOTS  registered slot-valid vector
occ  output  NUM_UNITS*CNT_W  registered occupancy count per unit
unit_full  output  NUM_UNITS  all slots valid (registered)
unit_last_free  output  NUM_UNITS  unit holds exactly one valid slot AND free_vld (combinational)
all_full  output  1  no enabled unit has a free slot
err_free_inval  output  1  sticky: free targeted a slot whose valid was already 0

Behaviour:
- Reset (async, rst=1): valid=0, occ=0, unit_full=0, err_free_inval=0, RR pointer=0, state=INIT. Combinational outputs are forced to 0 while in INIT.
- States:
  - INIT: 1 cycle after rst deasserts; alloc_gnt=0; free ignored; then RUN.
  - RUN: steady state.
  - There is no other state.
- Event priority in RUN, per edge:
  - (1) Any unit with unit_en[u]=0 has its valid slice cleared, occ=0.
  - (2) Else if hold=1: no change.
  - (3) Else if free_vld: clear the valid bits of enabled units where free_mask=1; alloc is suppressed (alloc_gnt=0 that cycle).
  - (4) Else if alloc_gnt: set valid at the granted slot.
- Grant (combinational, same cycle as alloc_req):
  - Condition: alloc_gnt = alloc_req & ~hold & ~free_vld & ~all_full & state==RUN.
  - Only enabled units are candidates.
  - RR_MODE=0: lowest-index enabled unit with any free slot.
  - RR_MODE=1: search starts at the unit after the last granted unit, wrapping modulo NUM_UNITS. The pointer updates only on an actual grant.
- Slot choice: lowest-index free slot within the chosen unit.
- Grant latency: the valid bit is set on the next clk edge, and occ increments in the same edge.
- occ:
  - Registered popcount of the next valid state.
  - Never exceeds SLOTS; no wrap.
  - Decrements by the number of bits actually cleared.
- unit_full[u] = (occ[u]==SLOTS) & unit_en[u], registered alongside occ.
- unit_last_free[u] = (popcount(valid[u])==1) & free_vld & ~hold.
- Invalid free: if free_vld & ~hold and any free_mask bit of an enabled unit targets valid=0, set err_free_inval. It clears only on rst. That bit has no other effect.
- Free bits for disabled units are ignored and do not raise the error.
- unit_en deasserting mid-operation: that unit's state is flushed on the next edge regardless of hold.
- rst asserting mid-operation: immediate return to reset values; INIT repeats.

Test Plan:
- rst pulse, release, alloc_req=1 continuously, NUM_UNITS=2, SLOTS=16, RR_MODE=0 -> no grant in INIT cycle; grants unit0 slot0..15, then unit1 slot0..15; all_full=1 after 32 grants; occ={16,16}; alloc_gnt=0 after.
- RR_MODE=1, both units empty, 4 consecutive alloc_req -> gnt_unit sequence 1,0,1,0 (pointer starts at 0, search starts at 1), gnt_slot 0,0,1,1.
- Unit0 holds slots 3 and 7; free_vld with mask bit 3 and alloc_req same cycle -> alloc_gnt=0, valid[3]=0 next edge, occ0=1. Next free of bit 7 -> unit_last_free[0]=1 that cycle, occ0=0 after.
- Free of slot 5 with valid[5]=0 -> err_free_inval=1 and stays 1; valid unchanged; cleared only by rst.
- unit_en[1] dropped with unit1 occ=9, hold=1 -> unit1 valid=0, occ1=0 next edge; allocation skips unit1 while disabled.
- hold=1 with alloc_req and free_vld -> no grant, valid and occ unchanged, unit_last_free=0.
